// File: rtl/shift_expander.sv
// shift_expander
//   Widening counterpart of the transform-path narrowing shifter. A signed
//   narrow sample is sign-extended and shifted left by a per-beat amount,
//   back up to accumulator width. The block is a two-stage valid/ready
//   pipeline with per-beat overflow detection and a saturating overflow
//   counter.
//
//   Optional feature macro: SHIFT_EXPANDER_SAT_EN
//     defined   - an overflowed beat outputs the saturated extreme value
//     undefined - an overflowed beat outputs the wrapped low OUTPUT_WIDTH bits
//     out_ovf and ovf_cnt behave the same in both builds.
//
// Ports
//   clk, rst           single clock; asynchronous active-high reset
//   in_valid/in_ready  input handshake; in_data is the signed sample and
//                      in_shift the unsigned left-shift amount
//   out_valid/out_ready output handshake; out_data is the signed result and
//                      out_ovf flags a beat that overflowed OUTPUT_WIDTH
//   ovf_cnt            saturating count of overflowed beats
//   ovf_clr            synchronous clear of ovf_cnt
module shift_expander #(
    parameter int INPUT_WIDTH  = 19,
    parameter int OUTPUT_WIDTH = 42,
    parameter int SHIFT_WIDTH  = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    input  logic [SHIFT_WIDTH-1:0]  in_shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_ovf,
    output logic [CNT_WIDTH-1:0]    ovf_cnt,
    input  logic                    ovf_clr
);

    // Full-precision width. It is widened to at least OUTPUT_WIDTH so that
    // the overflow slice [FULL-1:OUTPUT_WIDTH-1] is always well formed.
    localparam int RAW_WIDTH = INPUT_WIDTH + (1 << SHIFT_WIDTH) - 1;
    localparam int FULL      = (RAW_WIDTH > OUTPUT_WIDTH) ? RAW_WIDTH : OUTPUT_WIDTH;
    localparam int TOP_W     = FULL - OUTPUT_WIDTH + 1;

    logic                    s1_valid;
    logic [INPUT_WIDTH-1:0]  s1_data;
    logic [SHIFT_WIDTH-1:0]  s1_shift;

    logic                    s1_load;
    logic                    s2_load;
    logic [FULL-1:0]         full_ext;
    logic [FULL-1:0]         full_shl;
    logic [TOP_W-1:0]        top_bits;
    logic                    ovf_nxt;
    logic [OUTPUT_WIDTH-1:0] data_nxt;
    logic                    cnt_inc;

    // Stage advance: S2 drains or is empty; S1 refills as it empties.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign s1_load  = in_valid && (!s1_valid || s2_load);
    assign in_ready = !s1_valid || !out_valid || out_ready;

    always_comb begin
        full_ext = {{(FULL-INPUT_WIDTH){s1_data[INPUT_WIDTH-1]}}, s1_data};
        full_shl = full_ext << s1_shift;
        top_bits = full_shl[FULL-1:OUTPUT_WIDTH-1];
        // Result fits only if every bit from the output sign bit upward
        // is a copy of the sign.
        ovf_nxt  = !((&top_bits) || !(|top_bits));
        data_nxt = full_shl[OUTPUT_WIDTH-1:0];
`ifdef SHIFT_EXPANDER_SAT_EN
        if (ovf_nxt) begin
            if (full_shl[FULL-1])
                data_nxt = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
            else
                data_nxt = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end
`endif
    end

    assign cnt_inc = s2_load && ovf_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_shift <= in_shift;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Data and flag only change on a load, so they hold during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out_data  <= data_nxt;
                out_ovf   <= ovf_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A clear that coincides with an overflowed load keeps that one count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= cnt_inc ? CNT_WIDTH'(1) : '0;
        end else if (cnt_inc && (ovf_cnt != {CNT_WIDTH{1'b1}})) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_expander.sv
module tb_shift_expander;

    localparam int IW = 19;
    localparam int OW = 42;
    localparam int SW = 5;
    localparam int CW = 16;

`ifdef SHIFT_EXPANDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [SW-1:0] in_shift;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_ovf;
    logic [CW-1:0] ovf_cnt;
    logic          ovf_clr;

    int n_vec  = 0;
    int n_fail = 0;

    shift_expander #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .SHIFT_WIDTH (SW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shift (in_shift),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .ovf_cnt  (ovf_cnt),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] d;
        logic [SW-1:0] sh;
        logic [OW-1:0] exp;
        logic          ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat with out_ready high: invisible after the acceptance
    // edge, valid after the next edge.
    task automatic one_beat(input string name, input logic [IW-1:0] d,
                            input logic [SW-1:0] sh, input logic [OW-1:0] exp,
                            input logic ovf, input logic [CW-1:0] cnt);
        in_valid  = 1'b1;
        in_data   = d;
        in_shift  = sh;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk({name, "_early_valid"}, 64'(out_valid), 64'd0);
        tick();
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"},  64'(out_data),  64'(exp));
        chk({name, "_ovf"},   64'(out_ovf),   64'(ovf));
        chk({name, "_cnt"},   64'(ovf_cnt),   64'(cnt));
        tick();
        chk({name, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [CW-1:0] exp_cnt;
        logic [3:0]    pat;
        int            sent, got;
        logic          prev_stall;
        logic [OW-1:0] prev_data;

        vecs[0]  = '{19'h7FFFD, 5'd4,  42'h3FFFFFFFFD0, 1'b0};
        vecs[1]  = '{19'h3FFFF, 5'd31, SAT ? 42'h1FFFFFFFFFF : 42'h3FF80000000, 1'b1};
        vecs[2]  = '{19'h40000, 5'd31, SAT ? 42'h20000000000 : 42'h00000000000, 1'b1};
        vecs[3]  = '{19'h40000, 5'd0,  42'h3FFFFFC0000, 1'b0};
        vecs[4]  = '{19'h3FFFF, 5'd0,  42'h0000003FFFF, 1'b0};
        vecs[5]  = '{19'h00001, 5'd31, 42'h00080000000, 1'b0};
        vecs[6]  = '{19'h3FFFF, 5'd23, 42'h1FFFF800000, 1'b0};
        vecs[7]  = '{19'h3FFFF, 5'd24, SAT ? 42'h1FFFFFFFFFF : 42'h3FFFF000000, 1'b1};
        vecs[8]  = '{19'h40000, 5'd23, 42'h20000000000, 1'b0};
        vecs[9]  = '{19'h40000, 5'd24, SAT ? 42'h20000000000 : 42'h00000000000, 1'b1};
        vecs[10] = '{19'h7FFFF, 5'd31, 42'h3FF80000000, 1'b0};
        vecs[11] = '{19'h00000, 5'd31, 42'h00000000000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("rst_ovf_cnt",   64'(ovf_cnt),   64'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Table vectors
        exp_cnt = '0;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].ovf) exp_cnt = exp_cnt + 1'b1;
            one_beat($sformatf("vec%0d", i), vecs[i].d, vecs[i].sh,
                     vecs[i].exp, vecs[i].ovf, exp_cnt);
        end

        // Clear colliding with an overflowed load into S2 leaves a count of 1
        in_valid = 1'b1; in_data = 19'h3FFFF; in_shift = 5'd31;
        tick();
        in_valid = 1'b0; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_collide_cnt", 64'(ovf_cnt), 64'd1);
        chk("clr_collide_ovf", 64'(out_ovf), 64'd1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_plain_cnt", 64'(ovf_cnt), 64'd0);

        // Backpressure stream: k << 1 for k = 1..8, out_ready pattern 1,0,0,1
        pat = 4'b1001;
        sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            out_ready = pat[3 - (cyc % 4)];
            in_valid  = (sent < 8);
            in_data   = IW'(sent + 1);
            in_shift  = 5'd1;
            #1;
            chk("bp_in_ready", 64'(in_ready),
                64'(!((sent - got) == 2 && !out_ready)));
            if (prev_stall) begin
                chk("bp_stall_valid", 64'(out_valid), 64'd1);
                chk("bp_stall_data",  64'(out_data),  64'(prev_data));
            end
            if (out_valid && out_ready) begin
                chk("bp_data", 64'(out_data), 64'(2 * (got + 1)));
                got++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_received", 64'(got), 64'd8);
        tick();
        chk("bp_no_extra", 64'(out_valid), 64'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 19'h3FFFF; in_shift = 5'd31;
        tick();
        in_data = 19'h00005;
        tick();
        in_valid = 1'b0;
        chk("mid_full_ready", 64'(in_ready), 64'd0);
        chk("mid_cnt_before", 64'(ovf_cnt), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data",  64'(out_data),  64'd0);
        chk("mid_rst_cnt",   64'(ovf_cnt),   64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_no_out", 64'(out_valid), 64'd0);
        one_beat("post_rst", 19'h7FFFD, 5'd4, 42'h3FFFFFFFFD0, 1'b0, '0);

        // Counter saturation: 65537 overflowed beats at full rate
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 19'h40000; in_shift = 5'd31;
        repeat (65537) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("sat_cnt", 64'(ovf_cnt), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
